// File: rtl/pll_phase_ctrl.sv
// Phase-adjust and lock sequencer for the ECP5 PLL dynamic ports: filters LOCK,
// gates the downstream domain reset and plays out timed PHASESTEP pulse trains.
module pll_phase_ctrl #(
    parameter int unsigned SETUP_CYCLES       = 4,
    parameter int unsigned PULSE_CYCLES       = 4,
    parameter int unsigned GAP_CYCLES         = 4,
    parameter int unsigned SETTLE_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STEPS_W            = 8
) (
    input  logic               clk_i,
    input  logic               reset,
    input  logic               pll_locked_i,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_sel,
    input  logic               req_dir,
    input  logic [STEPS_W-1:0] req_steps,
    output logic [1:0]         phasesel,
    output logic               phasedir,
    output logic               phasestep,
    output logic               phaseloadreg,
    output logic               lock_ok,
    output logic               domain_rst_o,
    output logic               busy,
    output logic               done,
    output logic               err_unlock,
    output logic [STEPS_W-1:0] steps_done
);

    localparam int unsigned MAX_A   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int unsigned MAX_B   = (GAP_CYCLES > SETTLE_CYCLES) ? GAP_CYCLES : SETTLE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned LCNT_W  = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned SW1     = STEPS_W + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_PULSE  = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;

    logic              sync1_q, sync2_q;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              lock_ok_q, lock_ok_d;
    logic              domain_rst_q;

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sel_q, sel_d;
    logic               dir_q, dir_d;
    logic [STEPS_W-1:0] steps_q, steps_d;
    logic [STEPS_W-1:0] steps_done_q, steps_done_d;
    logic               phasestep_q, busy_q, done_q, done_d, err_q, err_d;
    logic               accept;

    // Lock filter: consecutive synchronized-high cycles, cleared on any low sample.
    always_comb begin
        lcnt_d    = '0;
        lock_ok_d = 1'b0;
        if (sync2_q) begin
            lcnt_d    = (lcnt_q == LCNT_W'(LOCK_STABLE_CYCLES)) ? lcnt_q : lcnt_q + LCNT_W'(1);
            lock_ok_d = (lcnt_q == LCNT_W'(LOCK_STABLE_CYCLES));
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            lcnt_q       <= '0;
            lock_ok_q    <= 1'b0;
            domain_rst_q <= 1'b1;
        end else begin
            sync1_q      <= pll_locked_i;
            sync2_q      <= sync1_q;
            lcnt_q       <= lcnt_d;
            lock_ok_q    <= lock_ok_d;
            domain_rst_q <= ~lock_ok_d;
        end
    end

    assign req_ready = (state_q == S_IDLE) & lock_ok_q & ~reset;
    assign accept    = req_valid & req_ready;

    // Step sequencer; SETTLE holds one extra cycle so done coincides with busy.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        sel_d        = sel_q;
        dir_d        = dir_q;
        steps_d      = steps_q;
        steps_done_d = steps_done_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d      = S_SETUP;
                    sel_d        = req_sel;
                    dir_d        = req_dir;
                    steps_d      = req_steps;
                    steps_done_d = '0;
                end
            end
            S_SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = (steps_q == '0) ? S_SETTLE : S_PULSE;
                end
            end
            S_PULSE: begin
                if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
                    cnt_d        = '0;
                    steps_done_d = steps_done_q + STEPS_W'(1);
                    state_d      = (({1'b0, steps_done_q} + SW1'(1)) < {1'b0, steps_q}) ? S_GAP : S_SETTLE;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_PULSE;
                end
            end
            S_SETTLE: begin
                if (done_q) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    done_d = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        // Lock loss wins over any in-flight transition, freezing the completed-pulse count.
        if ((state_q != S_IDLE) && !lock_ok_q) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            steps_done_d = steps_done_q;
            done_d       = 1'b0;
            err_d        = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sel_q        <= '0;
            dir_q        <= 1'b0;
            steps_q      <= '0;
            steps_done_q <= '0;
            phasestep_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            dir_q        <= dir_d;
            steps_q      <= steps_d;
            steps_done_q <= steps_done_d;
            phasestep_q  <= (state_d == S_PULSE);
            busy_q       <= (state_d != S_IDLE);
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign phasesel     = sel_q;
    assign phasedir     = dir_q;
    assign phasestep    = phasestep_q;
    assign phaseloadreg = 1'b0;
    assign lock_ok      = lock_ok_q;
    assign domain_rst_o = domain_rst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_unlock   = err_q;
    assign steps_done   = steps_done_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Randomized bench for pll_phase_ctrl: lock behaviour from a run-length model,
// request waveforms from the closed-form pulse/done timing rules.
module tb_pll_phase_ctrl;

    localparam int unsigned L    = 16;
    localparam int unsigned S    = 4;
    localparam int unsigned P    = 4;
    localparam int unsigned G    = 4;
    localparam int unsigned ST   = 16;
    localparam int unsigned SW   = 8;
    localparam int          MAXC = 20000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pll_locked_i = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_sel = 2'd0;
    logic          req_dir = 1'b0;
    logic [SW-1:0] req_steps = '0;
    logic [1:0]    phasesel;
    logic          phasedir, phasestep, phaseloadreg, lock_ok, domain_rst_o;
    logic          busy, done, err_unlock;
    logic [SW-1:0] steps_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit rst_at[MAXC];
    int run_len[MAXC];

    pll_phase_ctrl #(
        .SETUP_CYCLES(S), .PULSE_CYCLES(P), .GAP_CYCLES(G), .SETTLE_CYCLES(ST),
        .LOCK_STABLE_CYCLES(L), .STEPS_W(SW)
    ) dut (
        .clk_i(clk), .reset(reset), .pll_locked_i(pll_locked_i),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_dir(req_dir), .req_steps(req_steps), .phasesel(phasesel),
        .phasedir(phasedir), .phasestep(phasestep), .phaseloadreg(phaseloadreg),
        .lock_ok(lock_ok), .domain_rst_o(domain_rst_o), .busy(busy), .done(done),
        .err_unlock(err_unlock), .steps_done(steps_done)
    );

    always #5 clk = ~clk;

    // run_len[j]: consecutive high lock values driven up to edge j since the last reset.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < MAXC) begin
            rst_at[cyc] = reset;
            run_len[cyc-1] = !pll_locked_i ? 0 :
                             (rst_at[cyc-1] || cyc == 1) ? 1 : run_len[cyc-2] + 1;
        end
    end

    initial begin
        #(10 * 30000);
        $display("FAIL watchdog: simulation stuck at cycle %0d", cyc);
        $fatal(1);
    end

    function automatic bit exp_lock(int e);
        if (e < 3 || e >= MAXC) return 1'b0;
        if (rst_at[e] || rst_at[e-1] || rst_at[e-2]) return 1'b0;
        return run_len[e-3] >= int'(L) + 1;
    endfunction

    function automatic bit exp_step(int n, int t);
        int st;
        for (int k = 0; k < n; k++) begin
            st = 1 + S + k * (P + G);
            if (t >= st && t <= st + P - 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int exp_sdone(int n, int t);
        int c = 0;
        for (int k = 0; k < n; k++)
            if (1 + S + k * (P + G) + P - 1 < t) c++;
        return c;
    endfunction

    function automatic int exp_done_t(int n);
        return (n == 0) ? 1 + S + ST : 1 + S + n * P + (n - 1) * G + ST;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [1:0] sel, input logic dir, input logic [SW-1:0] n,
                             output int a, output bit ok);
        int w = 0;
        req_sel = sel; req_dir = dir; req_steps = n;
        while (req_ready !== 1'b1 && w < 500) begin tick(); w++; end
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_req_timeout: req_ready=%b, required 1", req_ready);
            ok = 1'b0; a = cyc;
            return;
        end
        req_valid = 1'b1;
        tick();
        a = cyc; ok = 1'b1;
    endtask

    task automatic test_reset();
        logic [18:0] obs, exp;
        reset = 1'b1; pll_locked_i = 1'b0; req_valid = 1'b0;
        repeat (3) tick();
        obs = {lock_ok, domain_rst_o, busy, done, err_unlock, phasestep, phaseloadreg, req_ready,
               phasesel, phasedir, steps_done};
        exp = {1'b0, 1'b1, 6'b0, 2'b00, 1'b0, SW'(0)};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_values: got %h, required %h", obs, exp);
        end
    endtask

    task automatic check_lock_window(input string name, input int cycles);
        bit e;
        for (int t = 1; t <= cycles; t++) begin
            tick();
            e = exp_lock(cyc);
            n_tests++;
            if (lock_ok !== e || domain_rst_o !== !e || req_ready !== (e && !busy)) begin
                n_fail++;
                $display("FAIL %s cyc=%0d: lock_ok=%b rst=%b ready=%b, required lock_ok=%b",
                         name, cyc, lock_ok, domain_rst_o, req_ready, e);
            end
        end
    endtask

    task automatic test_lock_rise();
        pll_locked_i = 1'b1;
        tick();
        reset = 1'b0;
        check_lock_window("lock_rise", L + 6);
    endtask

    task automatic test_request(input logic [1:0] sel, input logic dir, input logic [SW-1:0] n,
                                input bit keep_valid);
        int a, dt;
        bit ok;
        start_req(sel, dir, n, a, ok);
        if (!ok) return;
        if (!keep_valid) req_valid = 1'b0;
        dt = exp_done_t(int'(n));
        for (int t = 1; t <= dt + 1; t++) begin
            if (t > 1) tick();
            n_tests++;
            if (phasestep !== exp_step(int'(n), t) || busy !== (t <= dt) || done !== (t == dt) ||
                err_unlock !== 1'b0 || req_ready !== (t > dt)) begin
                n_fail++;
                $display("FAIL req_ctrl n=%0d t=%0d: step=%b busy=%b done=%b err=%b ready=%b, required step=%b busy=%b done=%b err=0 ready=%b",
                         n, t, phasestep, busy, done, err_unlock, req_ready,
                         exp_step(int'(n), t), t <= dt, t == dt, t > dt);
            end
            if (t <= dt) begin
                n_tests++;
                if ({phasesel, phasedir, steps_done} !== {sel, dir, SW'(exp_sdone(int'(n), t))}) begin
                    n_fail++;
                    $display("FAIL req_fields n=%0d t=%0d: sel=%0d dir=%b steps_done=%0d, required %0d %b %0d",
                             n, t, phasesel, phasedir, steps_done, sel, dir, exp_sdone(int'(n), t));
                end
            end
        end
    endtask

    task automatic test_random_requests();
        for (int i = 0; i < 6; i++)
            test_request(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         SW'($urandom_range(0, 4)), 1'b0);
    endtask

    task automatic test_back_to_back();
        test_request(2'd1, 1'b0, SW'(2), 1'b1);
        test_request(2'd3, 1'b1, SW'(1), 1'b0);
    endtask

    task automatic test_unlock();
        int a;
        bit ok, e;
        start_req(2'd2, 1'b1, SW'(3), a, ok);
        req_valid = 1'b0;
        if (!ok) return;
        for (int t = 1; t <= 24; t++) begin
            if (t > 1) tick();
            e = exp_lock(cyc);
            n_tests++;
            if (phasestep !== (t < 17 && exp_step(3, t)) || err_unlock !== (t == 17) ||
                busy !== (t < 17) || done !== 1'b0 ||
                steps_done !== SW'(exp_sdone(3, (t < 17) ? t : 16)) ||
                lock_ok !== e || domain_rst_o !== !e) begin
                n_fail++;
                $display("FAIL unlock t=%0d: step=%b err=%b busy=%b done=%b sd=%0d lock=%b rst=%b, required step=%b err=%b busy=%b done=0 sd=%0d lock=%b",
                         t, phasestep, err_unlock, busy, done, steps_done, lock_ok, domain_rst_o,
                         t < 17 && exp_step(3, t), t == 17, t < 17, exp_sdone(3, (t < 17) ? t : 16), e);
            end
            if (t == 13) pll_locked_i = 1'b0;
        end
        pll_locked_i = 1'b1;
        req_sel = 2'd0; req_dir = 1'b1; req_steps = SW'(1); req_valid = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            n_tests++;
            if (req_ready !== exp_lock(cyc) || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL unlock_refuse cyc=%0d: ready=%b busy=%b, required ready=%b busy=0",
                         cyc, req_ready, busy, exp_lock(cyc));
            end
        end
        test_request(2'd0, 1'b1, SW'(1), 1'b0);
    endtask

    task automatic test_glitch();
        pll_locked_i = 1'b0;
        tick();
        pll_locked_i = 1'b1;
        check_lock_window("glitch", L + 8);
    endtask

    task automatic test_lock_random();
        for (int i = 0; i < 200; i++) begin
            pll_locked_i = ($urandom_range(0, 24) != 0);
            check_lock_window("lock_random", 1);
        end
        pll_locked_i = 1'b1;
        check_lock_window("lock_random_tail", L + 4);
    endtask

    task automatic test_reset_mid();
        int a;
        bit ok;
        logic [18:0] obs, exp;
        start_req(2'd1, 1'b1, SW'(3), a, ok);
        if (!ok) return;
        req_steps = SW'(2); req_sel = 2'd2; req_dir = 1'b0;
        while (cyc < a + 10) tick();
        reset = 1'b1;
        tick();
        obs = {lock_ok, domain_rst_o, busy, done, err_unlock, phasestep, phaseloadreg, req_ready,
               phasesel, phasedir, steps_done};
        exp = {1'b0, 1'b1, 6'b0, 2'b00, 1'b0, SW'(0)};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_gap: got %h, required %h", obs, exp);
        end
        reset = 1'b0;
        test_request(2'd2, 1'b0, SW'(2), 1'b0);
    endtask

    initial begin
        test_reset();
        test_lock_rise();
        test_random_requests();
        test_back_to_back();
        test_unlock();
        test_glitch();
        test_lock_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
